icache_param: RTL and testbench
===============================

ICACHE_PARAM -- requirements
Module: icache_param

Interface
Parameters:
REQ-001 SETS, default 16: number of direct-mapped lines; power of two, minimum 2.
REQ-002 BLKWORDS, default 2: 32-bit words per line; power of two, minimum 1.
Ports:
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 imemREN  in  1  datapath instruction read request.
REQ-006 imemaddr  in  32  datapath fetch byte address; bits [1:0] ignored.
REQ-007 iflush  in  1  invalidate every line.
REQ-008 ihit  out  1  imemload is valid this cycle.
REQ-009 imemload  out  32  fetched instruction word.
REQ-010 iREN  out  1  memory read request.
REQ-011 iaddr  out  32  memory word address, bits [1:0] = 0.
REQ-012 iwait  in  1  memory busy; iload is valid when iwait=0 and iREN=1.
REQ-013 iload  in  32  memory read data.

Function
REQ-014 Address split, LSB first: byte offset 2b; word offset WB=log2(BLKWORDS) bits; index IB=log2(SETS) bits; tag 30-WB-IB bits.
REQ-015 Line contents: valid bit, tag, BLKWORDS data words.
REQ-016 States: IDLE and FILL only.
REQ-017 IDLE hit, defined as imemREN=1 AND line valid AND tag match: ihit=1 combinationally in the same cycle, imemload=selected word, state stays IDLE.
REQ-018 IDLE miss, defined as imemREN=1 with no hit: ihit=0; latch tag and index of imemaddr; clear fill counter; next state FILL.
REQ-019 IDLE with imemREN=0: ihit=0, iREN=0, no state change.
REQ-020 FILL: iREN=1; iaddr={latched tag, latched index, counter, 2'b00}; ihit=0.
REQ-021 FILL, each cycle with iwait=0: write iload to the counter's word of the latched line; increment counter.
REQ-022 FILL, on the beat with counter=BLKWORDS-1 and iwait=0: write tag, set valid, next state IDLE.
REQ-023 Requested data is delivered by an IDLE hit the cycle after FILL ends, so miss latency is the sum of the BLKWORDS memory beats plus 1 cycle.
REQ-024 Valid bit is never set before the final beat; a partly filled line reads as a miss.
REQ-025 imemaddr or imemREN changing during FILL has no effect; the latched fill runs to completion.
REQ-026 Counter wraps to 0 on each new miss; BLKWORDS=1 gives a one-beat fill.
REQ-027 iflush in IDLE: all valid bits cleared at the next edge; ihit is forced to 0 in that cycle.
REQ-028 iflush in FILL: fill aborts; iREN=0 from the next cycle; all valid bits cleared; next state IDLE; the partial line stays invalid.
REQ-029 Outputs are 0 whenever not driven by REQ-017 or REQ-020.

Reset
REQ-030 nRST low: state=IDLE, all valid/tag/data=0, counter=0, latched tag/index=0; ihit=0, iREN=0, iaddr=0, imemload=0 immediately.
REQ-031 nRST asserted mid-FILL abandons the fill; no line becomes valid.

Structure
REQ-032 word_t comes from cpu_types_pkg; a parametrised line-struct typedef and the address-field width functions belong in a shared icache package.
REQ-033 The storage array with one write port and one combinational read port is a natural sub-module named icache_array; the FSM, counter and address mux stay in icache_param.
REQ-034 An elaboration-time check rejects SETS or BLKWORDS values that are not powers of two.

Verification
All scenarios use SETS=16, BLKWORDS=2.
REQ-035 Cold miss at 0x40 with iwait=0 -> iaddr 0x40 then 0x44 on consecutive cycles; ihit=1 on cycle 3 with the word at 0x40.
REQ-036 After REQ-035, read 0x44 -> ihit=1 the same cycle, no iREN.
REQ-037 Read 0xC0 (index 8, tag 1) after 0x40 -> miss and refill; a following read of 0x40 misses again (conflict eviction).
REQ-038 iwait held high 3 cycles per beat -> iaddr held stable through the stall; ihit only after both beats.
REQ-039 iflush after line 8 is filled -> the next read of 0x40 misses; iflush during beat 1 -> iREN drops and the line stays invalid.
REQ-040 nRST pulsed mid-FILL -> outputs 0 immediately; the next read of 0x40 misses.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Basic datapath types shared across the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  // One 32-bit machine word.
  typedef logic [31:0] word_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/icache_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_param_pkg
//  Description : Shared types and address-field width helpers for the
//                parametrised direct-mapped instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_param_pkg;

  import cpu_types_pkg::*;

  // Controller states: serve lookups, or stream a line in from memory.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_e;

  // Index field width (log2 of the number of lines).
  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Word-offset field width (log2 of the words per line).
  function automatic int off_bits(input int blkwords);
    return $clog2(blkwords);
  endfunction

  // Tag field width: what is left of the 30-bit word address.
  function automatic int tag_bits(input int sets, input int blkwords);
    return 30 - idx_bits(sets) - off_bits(blkwords);
  endfunction

  // Fill counter width; at least one bit so single-word lines still have a counter.
  function automatic int cnt_bits(input int blkwords);
    return (off_bits(blkwords) == 0) ? 1 : off_bits(blkwords);
  endfunction

  // True when n is a non-zero power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage : icache_param_pkg
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
//  Module      : icache_array
//  Description : Line storage for the instruction cache. One write port used
//                by the fill engine, one combinational read port used by the
//                lookup, and a bulk valid-clear for flushes.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_array
  import cpu_types_pkg::*;
  import icache_param_pkg::*;
#(
  parameter int SETS     = 16,
  parameter int BLKWORDS = 2,
  localparam int IB = idx_bits(SETS),
  localparam int TW = tag_bits(SETS, BLKWORDS),
  localparam int CW = cnt_bits(BLKWORDS)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic          set_valid_i,
  input  logic [IB-1:0] widx_i,
  input  logic [CW-1:0] wword_i,
  input  logic [TW-1:0] wtag_i,
  input  logic [31:0]   wdata_i,
  input  logic [IB-1:0] ridx_i,
  input  logic [CW-1:0] rword_i,
  output logic          rvalid_o,
  output logic [TW-1:0] rtag_o,
  output logic [31:0]   rdata_o
);

  // One cache line: valid flag, tag, and the data words.
  typedef struct packed {
    logic                  valid;
    logic [TW-1:0]         tag;
    word_t [BLKWORDS-1:0]  data;
  } line_t;

  line_t lines_q [SETS];

  // Storage update: fill beats write one word; the last beat also commits
  // tag and valid. A flush in the same cycle wins over the valid set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        lines_q[s] <= '0;
      end
    end else begin
      if (wr_en_i) begin
        lines_q[widx_i].data[wword_i] <= wdata_i;
        if (set_valid_i) begin
          lines_q[widx_i].valid <= 1'b1;
          lines_q[widx_i].tag   <= wtag_i;
        end
      end
      if (flush_i) begin
        for (int s = 0; s < SETS; s++) begin
          lines_q[s].valid <= 1'b0;
        end
      end
    end
  end

  assign rvalid_o = lines_q[ridx_i].valid;
  assign rtag_o   = lines_q[ridx_i].tag;
  assign rdata_o  = lines_q[ridx_i].data[rword_i];

endmodule : icache_array
`default_nettype wire

// File: rtl/icache_param.sv
`default_nettype none
// ============================================================================
//  Module      : icache_param
//  Description : Parametrised direct-mapped instruction cache. Hits are
//                answered combinationally; a miss streams the whole line in
//                from memory word by word, then the lookup hits on the
//                following cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_param
  import cpu_types_pkg::*;
  import icache_param_pkg::*;
#(
  parameter int SETS     = 16,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IB = idx_bits(SETS);
  localparam int WB = off_bits(BLKWORDS);
  localparam int TW = tag_bits(SETS, BLKWORDS);
  localparam int CW = cnt_bits(BLKWORDS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BLKWORDS - 1);

  // Reject geometries the address split cannot represent.
  if (!is_pow2(SETS) || SETS < 2) begin : g_bad_sets
    $error("icache_param: SETS must be a power of two, at least 2");
  end
  if (!is_pow2(BLKWORDS)) begin : g_bad_blkwords
    $error("icache_param: BLKWORDS must be a power of two");
  end
  if (TW < 1) begin : g_bad_tag
    $error("icache_param: SETS*BLKWORDS leaves no tag bits");
  end

  icache_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [IB-1:0] idx_q, idx_d;

  logic [IB-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [CW-1:0] req_word;
  logic [31:0]   fill_addr;

  logic          line_valid;
  logic [TW-1:0] line_tag;
  word_t         line_word;

  logic lookup_hit;
  logic start_fill;
  logic beat_done;
  logic last_beat;
  logic unused_addr_bits;

  // Byte offset is irrelevant to a word-organised cache.
  assign unused_addr_bits = ^imemaddr[1:0];

  assign req_idx = imemaddr[IB+WB+1:WB+2];
  assign req_tag = imemaddr[31:IB+WB+2];

  // With single-word lines there is no word-offset field and the counter
  // never contributes to the memory address.
  if (WB == 0) begin : g_single_word
    assign req_word  = '0;
    assign fill_addr = {tag_q, idx_q, 2'b00};
  end else begin : g_multi_word
    assign req_word  = imemaddr[WB+1:2];
    assign fill_addr = {tag_q, idx_q, cnt_q, 2'b00};
  end

  assign lookup_hit = imemREN && line_valid && (line_tag == req_tag);
  // A flush in IDLE takes priority over starting a new fill.
  assign start_fill = (state_q == IDLE) && !iflush && imemREN && !lookup_hit;
  // A flush during FILL aborts the fill, so that beat is not committed.
  assign beat_done  = (state_q == FILL) && !iwait && !iflush;
  assign last_beat  = beat_done && (cnt_q == LAST_BEAT);

  icache_array #(
    .SETS     (SETS),
    .BLKWORDS (BLKWORDS)
  ) u_array (
    .CLK         (CLK),
    .nRST        (nRST),
    .flush_i     (iflush),
    .wr_en_i     (beat_done),
    .set_valid_i (last_beat),
    .widx_i      (idx_q),
    .wword_i     (cnt_q),
    .wtag_i      (tag_q),
    .wdata_i     (iload),
    .ridx_i      (req_idx),
    .rword_i     (req_word),
    .rvalid_o    (line_valid),
    .rtag_o      (line_tag),
    .rdata_o     (line_word)
  );

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter FILL on a miss, leave on the last beat or a flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_fill) state_d = FILL;
      FILL:    if (iflush || last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fill bookkeeping next-state: latch the missing line, step the word counter.
  always_comb begin
    cnt_d = cnt_q;
    tag_d = tag_q;
    idx_d = idx_q;
    if (start_fill) begin
      cnt_d = '0;
      tag_d = req_tag;
      idx_d = req_idx;
    end else if (beat_done) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Fill bookkeeping registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
      tag_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      idx_q <= idx_d;
    end
  end

  // Outputs: hit data in IDLE, memory request in FILL, zero otherwise.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state_q)
      IDLE: begin
        if (lookup_hit && !iflush) begin
          ihit     = 1'b1;
          imemload = line_word;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = fill_addr;
      end
      default: ;
    endcase
  end

endmodule : icache_param
`default_nettype wire

// File: tb/tb_icache_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_param
//  Description : Self-checking bench for icache_param (SETS=16, BLKWORDS=2):
//                directed vector table, reset/flush sequences, and a random
//                run against a behavioural cache model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_param;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int n_vec = 0;
  int n_bad = 0;

  icache_param #(
    .SETS     (16),
    .BLKWORDS (2)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .iflush   (iflush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Backing memory contents: a distinct value for every word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory answers only when not stalling; garbage otherwise.
  always_comb begin
    iload = iwait ? 32'hDEAD_BEEF : memf(iaddr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic eh, input logic [31:0] el,
                            input logic er, input logic [31:0] ea);
    check({tag, ".ihit"},     {31'd0, ihit}, {31'd0, eh});
    check({tag, ".imemload"}, imemload,      el);
    check({tag, ".iREN"},     {31'd0, iREN}, {31'd0, er});
    check({tag, ".iaddr"},    iaddr,         ea);
  endtask

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        fl;
    logic        wt;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ren, input logic [31:0] a, input logic fl, input logic wt,
                     input logic eh, input logic [31:0] el, input logic er, input logic [31:0] ea);
    vec_t v;
    v.ren = ren; v.addr = a; v.fl = fl; v.wt = wt;
    v.e_hit = eh; v.e_load = el; v.e_ren = er; v.e_iaddr = ea;
    tbl.push_back(v);
  endtask

  // Random-phase model state: one entry per line, plus the fill in progress.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  bit          m_fill;
  int          m_beat;
  logic [31:0] m_base;

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge CLK);
    #1;
    imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    imemREN = 1'b0;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // ---------------- directed vector table ----------------
    // cold miss at 0x40, two beats, hit next cycle
    add(1, 32'h40,  0, 0,  0, 0,              0, 0);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h40);
    add(1, 32'h80,  0, 0,  0, 0,              1, 32'h44);
    add(1, 32'h40,  0, 0,  1, memf(32'h40),   0, 0);
    add(1, 32'h44,  0, 0,  1, memf(32'h44),   0, 0);
    // conflict on line 8: 0xC0 evicts 0x40, then 0x40 evicts 0xC0
    add(1, 32'hC0,  0, 0,  0, 0,              0, 0);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'hC0);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'hC4);
    add(1, 32'hC4,  0, 0,  1, memf(32'hC4),   0, 0);
    add(1, 32'h40,  0, 0,  0, 0,              0, 0);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h40);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h44);
    add(1, 32'h40,  0, 0,  1, memf(32'h40),   0, 0);
    add(1, 32'hC0,  0, 0,  0, 0,              0, 0);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'hC0);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'hC4);
    add(0, 32'h0,   0, 0,  0, 0,              0, 0);
    // stalled fill of 0x100: three wait cycles per beat, address changes ignored
    add(1, 32'h100, 0, 1,  0, 0,              0, 0);
    add(1, 32'h104, 0, 1,  0, 0,              1, 32'h100);
    add(0, 32'h0,   0, 1,  0, 0,              1, 32'h100);
    add(1, 32'h40,  0, 1,  0, 0,              1, 32'h100);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h100);
    add(1, 32'h100, 0, 1,  0, 0,              1, 32'h104);
    add(0, 32'h0,   0, 1,  0, 0,              1, 32'h104);
    add(0, 32'h0,   0, 1,  0, 0,              1, 32'h104);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h104);
    add(1, 32'h100, 0, 0,  1, memf(32'h100),  0, 0);
    add(1, 32'h104, 0, 0,  1, memf(32'h104),  0, 0);
    // refill 0x40, flush in IDLE forces ihit low, next read misses
    add(1, 32'h40,  0, 0,  0, 0,              0, 0);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h40);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h44);
    add(1, 32'h40,  0, 0,  1, memf(32'h40),   0, 0);
    add(1, 32'h40,  1, 0,  0, 0,              0, 0);
    add(1, 32'h40,  0, 0,  0, 0,              0, 0);
    // flush on the second beat aborts; iREN drops, line stays invalid
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h40);
    add(0, 32'h0,   1, 0,  0, 0,              1, 32'h44);
    add(0, 32'h0,   0, 0,  0, 0,              0, 0);
    add(1, 32'h40,  0, 0,  0, 0,              0, 0);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h40);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h44);
    add(1, 32'h44,  0, 0,  1, memf(32'h44),   0, 0);
    // 0x100 was flushed too
    add(1, 32'h100, 0, 0,  0, 0,              0, 0);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h100);
    add(0, 32'h0,   0, 0,  0, 0,              1, 32'h104);
    add(0, 32'h0,   0, 0,  0, 0,              0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      imemREN  = tbl[i].ren;
      imemaddr = tbl[i].addr;
      iflush   = tbl[i].fl;
      iwait    = tbl[i].wt;
      @(negedge CLK);
      check_outs($sformatf("vec%0d", i), tbl[i].e_hit, tbl[i].e_load,
                 tbl[i].e_ren, tbl[i].e_iaddr);
      @(posedge CLK); #1;
    end

    // ---------------- reset pulse mid-FILL ----------------
    // 0x40 is valid here; 0x140 maps to the same line with another tag.
    imemREN = 1'b1; imemaddr = 32'h140; iflush = 1'b0; iwait = 1'b1;
    @(posedge CLK); #1;
    imemREN = 1'b0;
    check("rstfill.iREN_before", {31'd0, iREN}, 32'd1);
    check("rstfill.iaddr_before", iaddr, 32'h140);
    #1 nRST = 1'b0;
    #1;
    check_outs("rstfill.async", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1; iwait = 1'b0;
    imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    check_outs("rstfill.miss", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    check("rstfill.refill_addr", iaddr, 32'h40);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    check_outs("rstfill.hit", 1'b1, memf(32'h40), 1'b0, 32'h0);

    // ---------------- random run against the behavioural model ----------------
    imemREN = 1'b0; iflush = 1'b0; iwait = 1'b0;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int s = 0; s < 16; s++) begin
      m_valid[s] = 1'b0;
      m_tag[s]   = 0;
    end
    m_fill = 1'b0; m_beat = 0; m_base = '0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        r_ren, r_fl, r_wt, e_hit, e_ren;
      logic [31:0] r_addr, e_load, e_iaddr;
      int unsigned a_idx, a_tag;

      r_ren  = ($urandom_range(0, 3) != 0);
      r_addr = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 15) << 3) |
               ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      r_wt   = ($urandom_range(0, 2) == 0);
      r_fl   = ($urandom_range(0, 39) == 0);
      if (!m_fill && r_fl) r_ren = 1'b0;
      imemREN = r_ren; imemaddr = r_addr; iwait = r_wt; iflush = r_fl;

      a_idx = (r_addr >> 3) % 16;
      a_tag = r_addr >> 7;
      if (!m_fill) begin
        e_hit   = r_ren && m_valid[a_idx] && (m_tag[a_idx] == a_tag) && !r_fl;
        e_load  = e_hit ? memf(r_addr & ~32'h3) : 32'h0;
        e_ren   = 1'b0;
        e_iaddr = 32'h0;
      end else begin
        e_hit   = 1'b0;
        e_load  = 32'h0;
        e_ren   = 1'b1;
        e_iaddr = m_base + 32'(4 * m_beat);
      end

      @(negedge CLK);
      check_outs($sformatf("rand%0d", cyc), e_hit, e_load, e_ren, e_iaddr);

      // Advance the model across the coming clock edge.
      if (m_fill) begin
        if (r_fl) begin
          for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
          m_fill = 1'b0;
        end else if (!r_wt) begin
          m_beat++;
          if (m_beat == 2) begin
            m_valid[(m_base >> 3) % 16] = 1'b1;
            m_tag[(m_base >> 3) % 16]   = m_base >> 7;
            m_fill = 1'b0;
          end
        end
      end else begin
        if (r_fl) begin
          for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
        end else if (r_ren && !e_hit) begin
          m_fill = 1'b1;
          m_beat = 0;
          m_base = r_addr & ~32'h7;
        end
      end

      @(posedge CLK); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_icache_param
`default_nettype wire
